rhs_spi_slave: RTL and testbench
================================

// Module: rhs_spi_slave
//
// PURPOSE
//  SPI target (responder) for the 32-bit command/response frames issued by the RHS SPI master.
//  Oversamples SCLK/CS/MOSI on the system clock; it never uses SCLK as a clock.
//  Deserialises one MOSI command word per CS-low frame and serialises a caller-supplied MISO
//  response word in the same frame.
//  Used as a headstage/chip emulator in loopback builds and as a link endpoint on the far board.
//
// PARAMETERS
//  FRAME_BITS   32  bits per CS-low frame, MSB first
//  SYNC_STAGES  2   synchroniser depth for SCLK, CS and MOSI (min 2)
//
// PORTS
//  clk          in   1   system clock; must be >= 8x SCLK frequency
//  rstn         in   1   asynchronous, active-low reset
//  SCLK         in   1   SPI clock from master; idles low (mode 0)
//  CS           in   1   chip select from master, active low
//  MOSI         in   1   serial command data from master
//  MISO         out  1   serial response data to master
//  tx_data      in   32  response word; sampled once at frame start
//  rx_data      out  32  last complete command word received
//  rx_valid     out  1   1-cycle pulse: rx_data updated with a good frame
//  frame_error  out  1   1-cycle pulse: frame ended with bit count != FRAME_BITS
//  busy         out  1   high from frame start until frame is retired
//
// BEHAVIOUR
//  Reset (async, rstn=0): MISO=0, rx_data=0, rx_valid=0, frame_error=0, busy=0,
//   state=IDLE, bit_count=0, shift registers=0, synchronisers=idle (SCLK=0, CS=1, MOSI=0).
//  Input path
//   - SCLK, CS and MOSI each pass through SYNC_STAGES flops.
//   - Edges are detected on synced SCLK/CS against one further registered copy.
//   - Pin-to-action latency is SYNC_STAGES+1 clk.
//  Mode 0
//   - MOSI is captured on SCLK rising.
//   - MISO is updated on SCLK falling.
//   - Bit 31 of the response is on MISO from frame start, before the first rising edge.
//  FSM
//   - IDLE: enters ACTIVE when synced CS is low (level, not edge). On entry:
//     tx_shift <= tx_data, MISO <= tx_data[31], bit_count <= 0, busy <= 1.
//   - ACTIVE, SCLK rise: rx_shift <= {rx_shift[30:0], MOSI_sync}.
//     bit_count increments, saturating at FRAME_BITS+1 (6-bit counter).
//   - ACTIVE, SCLK fall: if bit_count < FRAME_BITS, tx_shift <<= 1 and MISO <= next bit.
//     Otherwise MISO holds.
//   - ACTIVE, CS rise: go to FINISH.
//     If a SCLK edge and the CS rise are detected in the same clk, the SCLK edge is applied first.
//   - FINISH (exactly 1 clk), then go to IDLE with busy <= 0 and MISO <= 0:
//     - bit_count == FRAME_BITS: rx_data <= rx_shift, rx_valid = 1.
//     - otherwise: frame_error = 1 and rx_data holds its previous value.
//  Boundaries
//   - CS high: MISO is driven 0 (no tristate).
//   - tx_data changes mid-frame are ignored.
//   - A frame that re-asserts CS during FINISH is not lost, because IDLE is level-triggered.
//   - CS already low at reset release: the frame is joined mid-stream and retires with frame_error.
//   - SCLK edges while in IDLE are ignored.
//   - rx_valid and frame_error are never high together.
//   - rstn asserted mid-frame takes effect immediately (async) and the partial frame is dropped.
//
// STRUCTURE
//  - Shared header rhs_spi_defs.vh holds RHS_FRAME_BITS=32, the state encodings
//    (IDLE=0, ACTIVE=1, FINISH=2) and the minimum clk:SCLK ratio of 8.
//    The master uses the same header.
//  - One sub-module, spi_input_sync: parameterised N-flop synchroniser plus rise/fall pulse
//    outputs, with async active-low reset to a per-instance idle value. Instantiated for SCLK, CS and MOSI.
//
// TESTING
//  1. Loopback with the RHS master (SCLK = clk/8): master sends 0xA5C3_0F1E, tx_data = 0x1234_5678
//     -> rx_data = 0xA5C30F1E with a single rx_valid pulse.
//     Master data_out = 0x12345678 for at least one oversample_offset in 0..7.
//  2. Short frame of 16 SCLK pulses, then CS high
//     -> frame_error pulses once, rx_valid stays 0, rx_data keeps 0xA5C30F1E.
//  3. Long frame of 33 SCLK pulses
//     -> frame_error pulses once; MISO holds the final bit after bit 32.
//  4. Back-to-back frames 0x0000_0001 then 0xFFFF_FFFE, with CS high for only 2 clk between them
//     -> two rx_valid pulses carrying the correct words in order.
//  5. rstn pulled low after 10 bits of a frame
//     -> all outputs 0 in the same cycle; after release with CS high, a full frame
//        with tx_data = 0xDEAD_BEEF returns 0xDEADBEEF on MISO.
//  6. tx_data changed to 0x0 mid-frame
//     -> MISO continues the word latched at frame start (0x1234_5678).

Source files
------------

// File: rtl/rhs_spi_slave_pkg.sv
// rtl/rhs_spi_slave_pkg.sv - shared frame constants and FSM encoding for the RHS SPI link
package rhs_spi_slave_pkg;

    localparam int RHS_FRAME_BITS = 32;
    localparam int RHS_MIN_CLK_RATIO = 8;
    localparam int RHS_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2
    } rhs_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - N-flop synchroniser with rise/fall pulses on the synced level
module spi_input_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edge pulses compare the synced level with one extra registered copy.
    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/rhs_spi_slave.sv
// rtl/rhs_spi_slave.sv - oversampled mode-0 SPI target for 32-bit RHS command/response frames
module rhs_spi_slave
    import rhs_spi_slave_pkg::*;
#(
    parameter int FRAME_BITS  = RHS_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam logic [RHS_CNT_W-1:0] CNT_FULL = RHS_CNT_W'(FRAME_BITS);
    localparam logic [RHS_CNT_W-1:0] CNT_SAT  = RHS_CNT_W'(FRAME_BITS + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rstn (rstn),
        .din  (SCLK),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rstn (rstn),
        .din  (CS),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rstn (rstn),
        .din  (MOSI),
        .dout (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_s, cs_fall, mosi_rise, mosi_fall};

    rhs_state_t                state_q, state_nxt;
    logic [RHS_CNT_W-1:0]      bit_count;
    logic [FRAME_BITS-1:0]     tx_shift;
    logic [FRAME_BITS-1:0]     rx_shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // IDLE reacts to the CS level so a frame re-asserted during FINISH is still caught.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (!cs_s) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            bit_count   <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!cs_s) begin
                        tx_shift  <= tx_data;
                        MISO      <= tx_data[FRAME_BITS-1];
                        bit_count <= '0;
                    end else begin
                        MISO <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // SCLK edges are applied even in the cycle CS rise is seen.
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
                        if (bit_count != CNT_SAT) bit_count <= bit_count + 1'b1;
                    end
                    if (sclk_fall && (bit_count < CNT_FULL)) begin
                        tx_shift <= tx_shift << 1;
                        MISO     <= tx_shift[FRAME_BITS-2];
                    end
                end
                ST_FINISH: begin
                    MISO <= 1'b0;
                    if (bit_count == CNT_FULL) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: MISO <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rhs_spi_slave.sv
// tb/tb_rhs_spi_slave.sv - scoreboard bench driving the SPI target as a mode-0 master
module tb_rhs_spi_slave;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        SCLK = 1'b0;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [31:0] tx_data = 32'h0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic        busy;

    rhs_spi_slave dut (
        .clk         (clk),
        .rstn        (rstn),
        .SCLK        (SCLK),
        .CS          (CS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] model_rx = 32'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a frame of exactly 32 clocks yields its word; anything else is an error
    // that leaves the last good word in place.
    task automatic expect_frame(input int nbits, input logic [31:0] word);
        ev_t e;
        if (nbits == 32) begin
            model_rx = word;
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.data = model_rx;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (rstn && (rx_valid || frame_error)) begin
                check("pulse_exclusive", 64'(rx_valid & frame_error), 64'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got rx_valid=%b frame_error=%b expected none",
                             rx_valid, frame_error);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_err", 64'(frame_error), 64'(e.is_err));
                    check("rx_data", 64'(rx_data), 64'(e.data));
                end
            end
        end
    end

    // Master side: SCLK = clk/8, MOSI set while SCLK low, MISO sampled just before each rise.
    task automatic do_frame(input logic [31:0] mosi_w, input logic [31:0] tx_w, input int nbits,
                            input int tx_change_at, input int abort_at, input int gap);
        logic [63:0] got_bits = '0;
        logic [63:0] exp_bits = '0;
        int          done = 0;
        @(negedge clk);
        tx_data = tx_w;
        CS = 1'b0;
        if (abort_at < 0) expect_frame(nbits, mosi_w);
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) break;
            MOSI = (i < 32) ? mosi_w[31 - i] : 1'($urandom);
            if (i == tx_change_at) tx_data = 32'h0;
            repeat (4) @(negedge clk);
            got_bits = {got_bits[62:0], MISO};
            exp_bits = {exp_bits[62:0], (i < 32) ? tx_w[31 - i] : tx_w[0]};
            if (i == nbits / 2) check("busy_mid_frame", 64'(busy), 64'h1);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
            done++;
        end
        if (abort_at < 0) begin
            check("miso_word", got_bits, exp_bits);
            repeat (4) @(negedge clk);
            CS = 1'b1;
            MOSI = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'h0);
        repeat (2) @(negedge clk);
        check("busy_idle", 64'(busy), 64'h0);
    endtask

    initial begin : stim
        logic [31:0] w, t;
        int          nb;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({MISO, rx_data, rx_valid, frame_error, busy}), 64'h0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        do_frame(32'hA5C3_0F1E, 32'h1234_5678, 32, -1, -1, 10);
        wait_drain();
        do_frame(32'h0BAD_F00D, 32'h55AA_33CC, 16, -1, -1, 10);
        wait_drain();
        do_frame(32'h600D_CAFE, 32'h8000_0001, 33, -1, -1, 10);
        wait_drain();
        do_frame(32'h0000_0001, 32'hCAFE_0001, 32, -1, -1, 2);
        do_frame(32'hFFFF_FFFE, 32'hCAFE_0002, 32, -1, -1, 10);
        wait_drain();
        do_frame(32'h1357_9BDF, 32'h1234_5678, 32, 10, -1, 10);
        wait_drain();

        for (int k = 0; k < 6; k++) begin
            w = $urandom;
            t = $urandom;
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 34) : 32;
            do_frame(w, t, nb, -1, -1, $urandom_range(2, 12));
        end
        wait_drain();

        do_frame($urandom, $urandom, 32, -1, 10, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", 64'({MISO, rx_data, rx_valid, frame_error, busy}), 64'h0);
        model_rx = 32'h0;
        CS = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        do_frame(32'h0F0F_1234, 32'hDEAD_BEEF, 32, -1, -1, 10);
        wait_drain();

        @(negedge clk);
        rstn = 1'b0;
        model_rx = 32'h0;
        CS = 1'b0;
        tx_data = 32'h9ABC_DEF0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        do_frame(32'hFFFF_0000, 32'h9ABC_DEF0, 5, -1, -1, 10);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
